// File: rtl/seq_detect_scheduler.sv
// Round-robin scheduler feeding one serial run-of-ones detector shared by NUM_REQ requesters.
// Optional define SEQ_DETECT_SCHED_FIRST_POS_EN adds res_first_pos (bit index of the first hit).
module seq_detect_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int RUN_LEN = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]     req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [$clog2(NUM_REQ)-1:0]   res_id,
  output logic [$clog2(WIDTH+1)-1:0]   res_count,
  output logic                         res_hit,
`ifdef SEQ_DETECT_SCHED_FIRST_POS_EN
  output logic [$clog2(WIDTH)-1:0]     res_first_pos,
`endif
  output logic                         busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(WIDTH+1);
  localparam int BW  = $clog2(WIDTH);
  localparam int RW  = $clog2(RUN_LEN+1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] REPORT = 2'd2;

  logic [1:0]         state_r;
  logic [IDW-1:0]     last_grant_r;
  logic [WIDTH-1:0]   word_r;
  logic [BW-1:0]      bit_idx_r;
  logic [RW-1:0]      run_r;
  logic [CW-1:0]      count_r;
  logic               res_valid_r;
  logic [IDW-1:0]     res_id_r;
  logic               res_hit_r;
  logic               busy_r;
`ifdef SEQ_DETECT_SCHED_FIRST_POS_EN
  logic [BW-1:0]      first_pos_r;
`endif

  logic [IDW-1:0]     sel_s;
  logic [IDW-1:0]     idx_s;
  logic               found_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [RW-1:0]      run_nxt_s;
  logic               hit_s;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    sel_s   = '0;
    idx_s   = '0;
    found_s = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx_s = IDW'((int'(last_grant_r) + i) % NUM_REQ);
      if (!found_s && req_valid[idx_s]) begin
        found_s = 1'b1;
        sel_s   = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Grant only in IDLE; gated by rst_n so req_ready reads 0 throughout reset.
  always_comb begin
    grant_s = '0;
    if (rst_n && (state_r == IDLE) && found_s) begin
      grant_s[sel_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  // Saturating run counter; a saturated run keeps producing hits on every further one.
  always_comb begin
    run_nxt_s = '0;
    if (word_r[0]) begin
      run_nxt_s = (run_r == RW'(RUN_LEN)) ? run_r : run_r + RW'(1);
    end else begin
      run_nxt_s = '0;
    end
    hit_s = word_r[0] && (run_nxt_s == RW'(RUN_LEN));
  end

  // Scheduler FSM and detector datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= IDW'(NUM_REQ-1);
      word_r       <= '0;
      bit_idx_r    <= '0;
      run_r        <= '0;
      count_r      <= '0;
      res_valid_r  <= 1'b0;
      res_id_r     <= '0;
      res_hit_r    <= 1'b0;
      busy_r       <= 1'b0;
`ifdef SEQ_DETECT_SCHED_FIRST_POS_EN
      first_pos_r  <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            word_r       <= req_data[sel_s*WIDTH +: WIDTH];
            res_id_r     <= sel_s;
            last_grant_r <= sel_s;
            run_r        <= '0;
            bit_idx_r    <= '0;
            count_r      <= '0;
            res_hit_r    <= 1'b0;
`ifdef SEQ_DETECT_SCHED_FIRST_POS_EN
            first_pos_r  <= '0;
`endif
            busy_r       <= 1'b1;
            state_r      <= SHIFT;
          end
        end
        SHIFT: begin
          word_r    <= word_r >> 1;
          run_r     <= run_nxt_s;
          bit_idx_r <= bit_idx_r + BW'(1);
          if (hit_s) begin
            count_r   <= count_r + CW'(1);
            res_hit_r <= 1'b1;
`ifdef SEQ_DETECT_SCHED_FIRST_POS_EN
            if (!res_hit_r) begin
              first_pos_r <= bit_idx_r;
            end
`endif
          end
          if (bit_idx_r == BW'(WIDTH-1)) begin
            state_r     <= REPORT;
            res_valid_r <= 1'b1;
          end
        end
        REPORT: begin
          if (res_ready) begin
            state_r     <= IDLE;
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          res_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = grant_s;
  assign res_valid = res_valid_r;
  assign res_id    = res_id_r;
  assign res_count = count_r;
  assign res_hit   = res_hit_r;
  assign busy      = busy_r;
`ifdef SEQ_DETECT_SCHED_FIRST_POS_EN
  assign res_first_pos = first_pos_r;
`endif

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Scoreboard bench for seq_detect_scheduler: stimulus pushes expected results, a monitor pops on handshake.
module tb_seq_detect_scheduler;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           res_valid;
  logic           res_ready = 1'b1;
  logic [1:0]     res_id;
  logic [4:0]     res_count;
  logic           res_hit;
  logic           busy;
`ifdef SEQ_DETECT_SCHED_FIRST_POS_EN
  logic [3:0]     res_first_pos;
`endif

  seq_detect_scheduler dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_count(res_count), .res_hit(res_hit),
`ifdef SEQ_DETECT_SCHED_FIRST_POS_EN
    .res_first_pos(res_first_pos),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct { int id; int cnt; int fp; } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: protocol checks every cycle, result compare on each handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("grant_onehot", int'($countones(req_ready) <= 1), 1);
      if (busy) chk("no_grant_busy", int'(req_ready), 0);
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got id %0d count %0d expected none", res_id, res_count);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("res_id", int'(res_id), e.id);
          chk("res_count", int'(res_count), e.cnt);
          chk("res_hit", int'(res_hit), int'(e.cnt != 0));
`ifdef SEQ_DETECT_SCHED_FIRST_POS_EN
          chk("res_first_pos", int'(res_first_pos), e.fp);
`endif
        end
      end
    end
  end

  task automatic wait_grant(input logic [N-1:0] exp, output int n);
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("grant", int'(req_ready), int'(exp));
  endtask

  task automatic issue(input int id, input logic [W-1:0] d, input int cnt, input int fp, input bit push);
    int n;
    if (push) sb.push_back('{id, cnt, fp});
    req_data[id*W +: W] = d;
    req_valid[id] = 1'b1;
    wait_grant(N'(1) << id, n);
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_res(output int k);
    k = 1;
    @(negedge clk);
    while (!res_valid && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("res_valid_seen", int'(res_valid), 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    int n;
    // Reset state, with a requester already asking
    req_valid = 4'b0001;
    #12;
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_id", int'(res_id), 0);
    chk("rst_res_count", int'(res_count), 0);
    chk("rst_res_hit", int'(res_hit), 0);
    chk("rst_busy", int'(busy), 0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single word with latency check
    issue(0, 16'h003F, 1, 5, 1'b1);
    wait_res(k);
    chk("latency", k, 17);
    chk("busy_report", int'(busy), 1);

    // Directed words
    issue(1, 16'hFFFF, 11, 5, 1'b1);
    issue(1, 16'h00FF, 3, 5, 1'b1);
    issue(3, 16'h5555, 0, 0, 1'b1);
    issue(3, 16'hFBEF, 0, 0, 1'b1);
    drain();

    // Two requesters held valid: strict alternation
    sb.push_back('{0, 1, 5});
    sb.push_back('{2, 7, 9});
    sb.push_back('{0, 1, 5});
    sb.push_back('{2, 7, 9});
    req_data[0*W +: W] = 16'h003F;
    req_data[2*W +: W] = 16'hFFF0;
    req_valid = 4'b0101;
    for (int g = 0; g < 4; g++) begin
      wait_grant((g % 2 == 0) ? 4'b0001 : 4'b0100, n);
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    drain();

    // Backpressure in REPORT while another requester waits
    res_ready = 1'b0;
    issue(1, 16'h00FF, 3, 5, 1'b1);
    sb.push_back('{3, 1, 5});
    req_data[3*W +: W] = 16'h003F;
    req_valid[3] = 1'b1;
    wait_res(k);
    chk("bp_count", int'(res_count), 3);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("bp_valid", int'(res_valid), 1);
      chk("bp_id", int'(res_id), 1);
      chk("bp_count_hold", int'(res_count), 3);
      chk("bp_no_grant", int'(req_ready), 0);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    wait_grant(4'b1000, n);
    chk("grant_after_bp", n, 1);
    @(posedge clk);
    #1;
    req_valid[3] = 1'b0;
    drain();

    // Reset during SHIFT bit 7 discards the in-flight word
    issue(1, 16'hFFFF, 0, 0, 1'b0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("mid_count", int'(res_count), 2);
    chk("mid_busy", int'(busy), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_count", int'(res_count), 0);
    chk("arst_id", int'(res_id), 0);
    chk("arst_hit", int'(res_hit), 0);
    chk("arst_valid", int'(res_valid), 0);
    chk("arst_req_ready", int'(req_ready), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{0, 1, 5});
    sb.push_back('{1, 3, 5});
    req_data[0*W +: W] = 16'h003F;
    req_data[1*W +: W] = 16'h00FF;
    req_valid = 4'b0011;
    wait_grant(4'b0001, n);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    wait_grant(4'b0010, n);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    drain();
    repeat (5) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_detect_scheduler.md
Name: seq_detect_scheduler

Overview:
- Shares one serial run-of-ones detector between NUM_REQ requesters.
- Each requester offers a WIDTH-bit word. A round-robin arbiter grants one word at a time.
- The granted word is shifted LSB-first, one bit per clk, through an embedded run detector. The detector flags every bit that ends a run of at least RUN_LEN consecutive ones; overlapping runs count.
- The per-word hit count is returned with the requester ID on a valid/ready result port. The block sits between the packet front-end and the status/IRQ logic.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- WIDTH, 16, bits per word (>=RUN_LEN).
- RUN_LEN, 6, consecutive ones required for a hit (>=1).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester word valid
- req_data  in  NUM_REQ*WIDTH  words; requester i occupies bits [i*WIDTH +: WIDTH]
- req_ready  out  NUM_REQ  one-hot grant/accept; high only in IDLE for the chosen requester
- res_valid  out  1  result valid
- res_ready  in  1  result accepted by sink
- res_id  out  $clog2(NUM_REQ)  requester index of the result
- res_count  out  $clog2(WIDTH+1)  number of hit bits in the word
- res_hit  out  1  res_count != 0
- busy  out  1  state != IDLE

Behaviour:
- Reset values:
  - State = IDLE.
  - req_ready, res_valid, res_id, res_count, res_hit and busy are all 0.
  - Run counter = 0.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has first priority.
- FSM states are IDLE, SHIFT and REPORT.
- IDLE:
  - If any req_valid is high, select the first valid index searching from last_grant+1 with wrap.
  - req_ready[sel] = 1 combinationally in that cycle. The transfer happens in that cycle.
  - Latch the word, res_id = sel and last_grant = sel. Clear the run counter, bit index and count.
  - Go to SHIFT.
- SHIFT: exactly WIDTH cycles; bit k is processed in the k-th SHIFT cycle.
  - Bit = 1: run = min(run+1, RUN_LEN). The bit is a hit if the new run == RUN_LEN; a hit increments count.
  - Bit = 0: run = 0.
  - After bit WIDTH-1, go to REPORT.
- REPORT:
  - res_valid = 1; res_id, res_count and res_hit are held stable.
  - When res_valid and res_ready are both high, go to IDLE.
- Latency: accept in cycle T gives res_valid first high in cycle T+WIDTH+1.
  - Throughput is at most one word per WIDTH+2 cycles with res_ready tied high.
- No arbitration takes place outside IDLE; req_ready stays 0 while busy. Requesters must hold req_valid and req_data until accepted.
- The run counter is cleared at every word start. Runs never span two words.
- The saturating run counter keeps counting hits: with RUN_LEN ones followed by m further ones, the word has m+1 hits.
- res_count is bounded by WIDTH-RUN_LEN+1, so it never overflows.
- Changes to req_valid/req_data of the granted requester after acceptance have no effect.
- Reset asserted in any state, including mid-SHIFT or during REPORT backpressure:
  - Immediately returns to the reset values.
  - The in-flight word is discarded and no result is produced.

Optional Feature:
- Macro SEQ_DETECT_SCHED_FIRST_POS_EN.
- When defined:
  - Adds output res_first_pos, $clog2(WIDTH) bits: the bit index of the first hit in the word.
  - It is 0 when res_hit = 0. It is valid with res_valid and resets to 0.
- When undefined: the port and its register do not exist; all other behaviour is identical.

Test Plan:
- Defaults; req_valid[0] = 1, data 16'h003F -> req_ready[0] in accept cycle T; res_valid at T+17; res_id = 0, res_count = 1, res_hit = 1 (first_pos = 5 if enabled).
- req1 data 16'hFFFF -> res_id = 1, res_count = 11. req1 data 16'h00FF -> res_count = 3.
- req3 data 16'h5555, then 16'hFBEF (two runs of 5 split by zeros) -> res_count = 0, res_hit = 0 both times.
- req0 and req2 valid continuously with res_ready = 1 -> grant order 0, 2, 0, 2; req_ready never two-hot; no grant while busy.
- res_ready held 0 for 5 cycles in REPORT -> res_* stable, all req_ready = 0; accept on cycle 6, then IDLE grants the next requester.
- rst_n pulsed low during SHIFT bit 7 -> all outputs 0 asynchronously, no result emitted; after release, a req0 + req1 request gives requester 0 first.
